// File: rtl/soc_system_reset_seq.sv
// Software-triggered reset pulse sequencer with an Avalon-MM register file
// and a saturating rising-edge event counter on a synchronized fabric input.
module soc_system_reset_seq #(
  parameter int DEFAULT_PULSE_LEN = 16,
  parameter int HOLDOFF_CYCLES    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port,
  output logic        cnt_reset,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [15:0] DEF_LEN   = 16'(DEFAULT_PULSE_LEN);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYCLES);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        cnt_reset_nxt;
  logic        done_set;
  logic        sync_a, sync_in, sync_d, rise;
  logic        done, done_nxt, irq_en, irq_en_nxt;
  logic [15:0] pulse_len;
  logic [31:0] event_cnt;
  logic [31:0] rd_nxt;
  logic        wr, wr_ctrl, busy;
  logic        unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wr_ctrl      = wr & (address == 2'd1);
  assign busy         = (state != IDLE);
  assign rise         = sync_in & ~sync_d;
  assign unused_wdata = ^writedata[31:16];

  // Two-flop synchronizer plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a  <= 1'b0;
      sync_in <= 1'b0;
      sync_d  <= 1'b0;
    end else begin
      sync_a  <= in_port;
      sync_in <= sync_a;
      sync_d  <= sync_in;
    end
  end

  // Sequencer next state; the down-counter is shared by ASSERT and HOLDOFF.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cnt_reset_nxt = 1'b0;
    done_set      = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ctrl && writedata[0]) begin
          state_nxt     = ASSERT;
          cnt_nxt       = (pulse_len == 16'd0) ? 16'd1 : pulse_len;
          cnt_reset_nxt = 1'b1;
        end else begin
          cnt_nxt = 16'd0;
        end
      end
      ASSERT: begin
        if (cnt <= 16'd1) begin
          state_nxt = HOLDOFF;
          cnt_nxt   = HOLD_LOAD;
        end else begin
          cnt_nxt       = cnt - 16'd1;
          cnt_reset_nxt = 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt <= 16'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
          done_set  = 1'b1;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  // Sticky done (set beats clear) and interrupt enable.
  always_comb begin
    if (done_set) begin
      done_nxt = 1'b1;
    end else if (wr_ctrl && writedata[1]) begin
      done_nxt = 1'b0;
    end else begin
      done_nxt = done;
    end
    if (wr_ctrl) begin
      irq_en_nxt = writedata[2];
    end else begin
      irq_en_nxt = irq_en;
    end
  end

  // Read mux; registered below, so reads see pre-edge register values.
  always_comb begin
    case (address)
      2'd0:    rd_nxt = {29'd0, done, busy, sync_in};
      2'd1:    rd_nxt = {29'd0, irq_en, 2'b00};
      2'd2:    rd_nxt = {16'd0, pulse_len};
      default: rd_nxt = event_cnt;
    endcase
  end

  // State, control registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      cnt_reset <= 1'b0;
      done      <= 1'b0;
      irq_en    <= 1'b0;
      irq       <= 1'b0;
      pulse_len <= DEF_LEN;
      readdata  <= 32'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cnt_reset <= cnt_reset_nxt;
      done      <= done_nxt;
      irq_en    <= irq_en_nxt;
      irq       <= done_nxt & irq_en_nxt;
      readdata  <= rd_nxt;
      if (wr && (address == 2'd2)) begin
        pulse_len <= writedata[15:0];
      end else begin
        pulse_len <= pulse_len;
      end
    end
  end

  // Event counter: clear wins over a coincident edge, saturates at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_cnt <= 32'd0;
    end else if (wr && (address == 2'd3)) begin
      event_cnt <= 32'd0;
    end else if (rise && (event_cnt != 32'hFFFF_FFFF)) begin
      event_cnt <= event_cnt + 32'd1;
    end else begin
      event_cnt <= event_cnt;
    end
  end

endmodule
